// File: rtl/vending_fsm_param.sv
// Parametrised two-coin cola vending controller.
// Takes 0.5- and 1-unit coin pulses against a configurable price, then
// dispenses one cola and returns any change once the credit reaches the price.
// A cancel request refunds the held credit. All outputs are registered.
module vending_fsm_param #(
    parameter int         PRICE   = 5,
    parameter int         CNT_W   = 4,
    parameter logic [1:0] IDLE    = 2'b01,
    parameter logic [1:0] COLLECT = 2'b10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pi_money_half,
    input  logic             pi_money_one,
    input  logic             pi_cancel,
    output logic             po_cola,
    output logic             po_change_vld,
    output logic [CNT_W-1:0] po_change,
    output logic [CNT_W-1:0] po_credit
);

    // Price at two widths: one for the widened compare, one for change arithmetic.
    localparam logic [CNT_W:0]   PRICE_W  = (CNT_W+1)'(PRICE);
    localparam logic [CNT_W-1:0] PRICE_LO = CNT_W'(PRICE);

    logic [1:0]       state;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] credit_q;
    logic [CNT_W-1:0] credit_d;
    logic [CNT_W-1:0] change_q;
    logic [CNT_W-1:0] change_d;
    logic             cola_q;
    logic             cola_d;
    logic             changeVld_q;
    logic             changeVld_d;

    logic [CNT_W:0]   coinValue;
    logic [CNT_W:0]   heldCredit;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] sumLo;
    logic [CNT_W-1:0] changeAmt;
    logic             vend;
    logic             refund;

    // Credit only counts while collecting, so IDLE always starts from zero.
    // The sum is one bit wider than the credit so the price compare cannot wrap.
    assign coinValue  = {{(CNT_W-1){1'b0}}, pi_money_one, pi_money_half};
    assign heldCredit = (state == COLLECT) ? {1'b0, credit_q} : '0;
    assign sum        = heldCredit + coinValue;
    assign sumLo      = sum[CNT_W-1:0];
    assign changeAmt  = sumLo - PRICE_LO;
    assign vend       = (sum >= PRICE_W);
    assign refund     = pi_cancel && (sum != '0);

    // State, credit and the registered outputs; reset discards credit silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            credit_q    <= '0;
            cola_q      <= 1'b0;
            changeVld_q <= 1'b0;
            change_q    <= '0;
        end else begin
            state       <= state_d;
            credit_q    <= credit_d;
            cola_q      <= cola_d;
            changeVld_q <= changeVld_d;
            change_q    <= change_d;
        end
    end

    // Next state: vend beats cancel, cancel beats accumulating.
    always_comb begin
        state_d  = state;
        credit_d = credit_q;
        if (vend || refund) begin
            state_d  = IDLE;
            credit_d = '0;
        end else begin
            credit_d = sumLo;
            state_d  = (sum != '0) ? COLLECT : IDLE;
        end
    end

    // Output pulses; the change amount holds its last value between pulses.
    always_comb begin
        cola_d      = 1'b0;
        changeVld_d = 1'b0;
        change_d    = change_q;
        if (vend) begin
            cola_d = 1'b1;
            if (changeAmt != '0) begin
                changeVld_d = 1'b1;
                change_d    = changeAmt;
            end
        end else if (refund) begin
            changeVld_d = 1'b1;
            change_d    = sumLo;
        end
    end

    assign po_cola       = cola_q;
    assign po_change_vld = changeVld_q;
    assign po_change     = change_q;
    assign po_credit     = credit_q;

endmodule

// File: tb/tb_vending_fsm_param.sv
// Self-checking bench for vending_fsm_param (PRICE=5, CNT_W=4).
// Directed vectors carry hand-derived expectations; the random phase uses a
// small behavioural model. Expectations go through a scoreboard queue.
module tb_vending_fsm_param;

    localparam int         PRICE   = 5;
    localparam int         CNT_W   = 4;
    localparam logic [1:0] IDLE    = 2'b01;
    localparam logic [1:0] COLLECT = 2'b10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             moneyHalf = 1'b0;
    logic             moneyOne = 1'b0;
    logic             cancel = 1'b0;
    logic             cola;
    logic             changeVld;
    logic [CNT_W-1:0] change;
    logic [CNT_W-1:0] credit;

    vending_fsm_param #(
        .PRICE(PRICE),
        .CNT_W(CNT_W),
        .IDLE(IDLE),
        .COLLECT(COLLECT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pi_money_half(moneyHalf),
        .pi_money_one(moneyOne),
        .pi_cancel(cancel),
        .po_cola(cola),
        .po_change_vld(changeVld),
        .po_change(change),
        .po_credit(credit)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic       cola;
        logic       vld;
        logic [3:0] change;
        logic [3:0] credit;
    } expT;

    typedef struct {
        logic       half;
        logic       one;
        logic       cancel;
        logic       cola;
        logic       vld;
        logic [3:0] change;
        logic [3:0] credit;
    } vecT;

    expT sbQ[$];
    vecT vecs[$];
    int  checks = 0;
    int  errors = 0;

    int         mCredit = 0;
    logic [3:0] mChange = 4'd0;

    int sumV = 0;
    int vends = 0;
    int sumChange = 0;

    // Reference behaviour, advanced once per driven cycle.
    function automatic expT modelStep(input logic h, input logic o, input logic c);
        expT e;
        int  s;
        s = mCredit + int'(h) + 2 * int'(o);
        e.cola = 1'b0;
        e.vld  = 1'b0;
        if (s >= PRICE) begin
            e.cola = 1'b1;
            if (s != PRICE) begin
                e.vld   = 1'b1;
                mChange = 4'(s - PRICE);
            end
            mCredit = 0;
        end else if (c && s > 0) begin
            e.vld   = 1'b1;
            mChange = 4'(s);
            mCredit = 0;
        end else begin
            mCredit = s;
        end
        e.change = mChange;
        e.credit = 4'(mCredit);
        return e;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pops the next expectation and compares every output plus the state probe.
    task automatic checkOutput(input string tag);
        expT        e;
        logic [1:0] expState;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s scoreboard: got empty queue, expected an entry", tag);
            return;
        end
        e = sbQ.pop_front();
        expState = (e.credit == 4'd0) ? IDLE : COLLECT;
        checkVal({tag, " cola"},   int'(cola),      int'(e.cola));
        checkVal({tag, " vld"},    int'(changeVld), int'(e.vld));
        checkVal({tag, " change"}, int'(change),    int'(e.change));
        checkVal({tag, " credit"}, int'(credit),    int'(e.credit));
        checkVal({tag, " state"},  int'(dut.state), int'(expState));
    endtask

    // Drives one cycle of inputs, queues the expectation, then checks after the edge.
    task automatic applyStimulus(input logic h, input logic o, input logic c,
                                 input logic useTable, input expT tabExp, input string tag);
        expT e;
        @(negedge clk);
        moneyHalf = h;
        moneyOne  = o;
        cancel    = c;
        e = modelStep(h, o, c);
        if (useTable) sbQ.push_back(tabExp);
        else          sbQ.push_back(e);
        @(posedge clk);
        #1;
        checkOutput(tag);
    endtask

    task automatic addVec(input logic h, input logic o, input logic c,
                          input logic ec, input logic ev, input int ech, input int ecr);
        vecT v;
        v.half = h; v.one = o; v.cancel = c;
        v.cola = ec; v.vld = ev; v.change = 4'(ech); v.credit = 4'(ecr);
        vecs.push_back(v);
    endtask

    task automatic resetModel();
        mCredit = 0;
        mChange = 4'd0;
        sbQ.delete();
    endtask

    initial begin
        expT ex;
        expT dummy;
        dummy = '{1'b0, 1'b0, 4'd0, 4'd0};

        //       h  o  c  cola vld chg cred
        addVec(1, 0, 0, 0, 0, 0, 1);   // half x5
        addVec(1, 0, 0, 0, 0, 0, 2);
        addVec(1, 0, 0, 0, 0, 0, 3);
        addVec(1, 0, 0, 0, 0, 0, 4);
        addVec(1, 0, 0, 1, 0, 0, 0);   // exact price, no change
        addVec(0, 1, 0, 0, 0, 0, 2);   // one x3
        addVec(0, 1, 0, 0, 0, 0, 4);
        addVec(0, 1, 0, 1, 1, 1, 0);   // change 1
        addVec(0, 1, 0, 0, 0, 1, 2);   // one, half, cancel
        addVec(1, 0, 0, 0, 0, 1, 3);
        addVec(0, 0, 1, 0, 1, 3, 0);   // refund 3
        addVec(0, 0, 1, 0, 0, 3, 0);   // idle cancel: no pulse, amount holds
        addVec(1, 1, 0, 0, 0, 3, 3);   // both coins
        addVec(1, 1, 0, 1, 1, 1, 0);   // sum 6
        addVec(0, 1, 0, 0, 0, 1, 2);
        addVec(0, 1, 0, 0, 0, 1, 4);
        addVec(1, 1, 0, 1, 1, 2, 0);   // credit 4 + 3: max change
        addVec(0, 1, 0, 0, 0, 2, 2);
        addVec(0, 1, 0, 0, 0, 2, 4);
        addVec(1, 0, 1, 1, 0, 2, 0);   // vend wins over cancel
        addVec(1, 0, 0, 0, 0, 2, 1);
        addVec(0, 1, 0, 0, 0, 2, 3);
        addVec(0, 1, 0, 1, 0, 2, 0);   // vend
        addVec(1, 0, 0, 0, 0, 2, 1);   // back-to-back: new transaction from 0
        addVec(0, 0, 1, 0, 1, 1, 0);   // refund 1
        addVec(1, 0, 0, 0, 0, 1, 1);
        addVec(0, 1, 1, 0, 1, 3, 0);   // refund includes same-cycle coin
        addVec(1, 1, 1, 0, 1, 3, 0);   // from idle, all three inputs

        $display("[TB] start");
        #35;
        checkVal("reset cola",   int'(cola),      0);
        checkVal("reset vld",    int'(changeVld), 0);
        checkVal("reset change", int'(change),    0);
        checkVal("reset credit", int'(credit),    0);
        checkVal("reset state",  int'(dut.state), int'(IDLE));
        #5;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            ex.cola   = vecs[i].cola;
            ex.vld    = vecs[i].vld;
            ex.change = vecs[i].change;
            ex.credit = vecs[i].credit;
            applyStimulus(vecs[i].half, vecs[i].one, vecs[i].cancel, 1'b1, ex,
                          $sformatf("vec%0d", i));
        end

        // Reset mid-transaction with credit held and a nonzero stale amount.
        applyStimulus(0, 1, 0, 1'b0, dummy, "rst pre1");
        applyStimulus(0, 1, 0, 1'b0, dummy, "rst pre2");
        #4;
        rst_n = 1'b0;
        #1;
        checkVal("async cola",   int'(cola),      0);
        checkVal("async vld",    int'(changeVld), 0);
        checkVal("async change", int'(change),    0);
        checkVal("async credit", int'(credit),    0);
        checkVal("async state",  int'(dut.state), int'(IDLE));
        resetModel();
        #19;
        rst_n = 1'b1;
        applyStimulus(0, 0, 1, 1'b0, dummy, "post-rst cancel");
        applyStimulus(1, 0, 0, 1'b0, dummy, "post-rst half");
        applyStimulus(0, 0, 1, 1'b0, dummy, "post-rst refund");

        // Reset pulse landing while a vend pulse is high.
        applyStimulus(0, 1, 0, 1'b0, dummy, "vrst a");
        applyStimulus(0, 1, 0, 1'b0, dummy, "vrst b");
        applyStimulus(1, 1, 0, 1'b0, dummy, "vrst c");
        #4;
        rst_n = 1'b0;
        #1;
        checkVal("vend-rst cola",   int'(cola),      0);
        checkVal("vend-rst vld",    int'(changeVld), 0);
        checkVal("vend-rst change", int'(change),    0);
        resetModel();
        #19;
        rst_n = 1'b1;

        // Random traffic against the model, with coin conservation tracking.
        for (int i = 0; i < 10000; i++) begin
            logic h, o, c;
            h = 1'($urandom_range(0, 1));
            o = 1'($urandom_range(0, 1));
            c = 1'($urandom_range(0, 1));
            sumV += int'(h) + 2 * int'(o);
            applyStimulus(h, o, c, 1'b0, dummy, "rand");
            if (cola) vends++;
            if (changeVld) sumChange += int'(change);
        end
        checkVal("conservation", sumV, PRICE * vends + sumChange + int'(credit));
        checkVal("scoreboard drained", sbQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
